// File: rtl/cmp_pkg.sv
// Shared types for the relational comparator stage and its persistence monitor.
package cmp_pkg;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_GT = 2'b01,
        REL_LT = 2'b10
    } rel_e;

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        ALARM,
        RECOVER
    } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cmp_persist_monitor.sv
// Qualifies comparator GT flags over time into a registered alarm with
// hysteresis, counts alarm episodes and flags non-one-hot flag patterns.
module cmp_persist_monitor
    import cmp_pkg::*;
#(
    parameter int PERSIST = 4,
    parameter int CLEAR   = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    input  logic             clr_cnt,
    output logic             alarm,
    output logic             alarm_rise,
    output logic [CNT_W-1:0] evt_count,
    output logic             flag_err,
    output logic [1:0]       last_rel
);

    localparam int RUN_MAX = (PERSIST > CLEAR) ? PERSIST : CLEAR;
    localparam int RW      = $clog2(RUN_MAX + 1);
    localparam logic [RW-1:0] PERSIST_LAST = RW'(PERSIST - 1);
    localparam logic [RW-1:0] CLEAR_LAST   = RW'(CLEAR - 1);

    mon_state_e    state;
    logic [RW-1:0] run;
    rel_e          rel_q;
    logic          one_hot;
    logic          legal;
    logic          illegal;
    logic          enter;

    assign one_hot = ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) ||
                     ({eq, gt, lt} == 3'b001);
    assign legal   = in_valid && one_hot;
    assign illegal = in_valid && !one_hot;

    // Only fresh entries count as episodes; RECOVER->ALARM is a continuation.
    assign enter = legal && gt &&
                   (((state == IDLE) && (PERSIST == 1)) ||
                    ((state == ARMING) && (run == PERSIST_LAST)));

    assign last_rel = rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            run        <= '0;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            flag_err   <= 1'b0;
            rel_q      <= REL_EQ;
        end else begin
            alarm_rise <= enter;
            if (clr_cnt) begin
                flag_err <= 1'b0;
            end else if (illegal) begin
                flag_err <= 1'b1;
            end
            if (legal) begin
                rel_q <= eq ? REL_EQ : (gt ? REL_GT : REL_LT);
                case (state)
                    IDLE: begin
                        if (gt) begin
                            if (PERSIST == 1) begin
                                state <= ALARM;
                                alarm <= 1'b1;
                            end else begin
                                state <= ARMING;
                                run   <= RW'(1);
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    ARMING: begin
                        if (!gt) begin
                            state <= IDLE;
                            run   <= '0;
                        end else if (run == PERSIST_LAST) begin
                            state <= ALARM;
                            run   <= '0;
                            alarm <= 1'b1;
                        end else begin
                            run <= run + RW'(1);
                        end
                    end
                    ALARM: begin
                        if (!gt) begin
                            if (CLEAR == 1) begin
                                state <= IDLE;
                                alarm <= 1'b0;
                            end else begin
                                state <= RECOVER;
                                run   <= RW'(1);
                            end
                        end
                    end
                    RECOVER: begin
                        if (gt) begin
                            state <= ALARM;
                            run   <= '0;
                        end else if (run == CLEAR_LAST) begin
                            state <= IDLE;
                            run   <= '0;
                            alarm <= 1'b0;
                        end else begin
                            run <= run + RW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        run   <= '0;
                        alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enter),
        .clr   (clr_cnt),
        .count (evt_count)
    );

endmodule

// File: tb/tb_cmp_persist_monitor.sv
// Scoreboard bench: a behavioural run-length model predicts every output per cycle.
module tb_cmp_persist_monitor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       eq;
    logic       gt;
    logic       lt;
    logic       clr_cnt;
    logic       alarm;
    logic       alarm_rise;
    logic [7:0] evt_count;
    logic       flag_err;
    logic [1:0] last_rel;
    logic       alarm_b;
    logic       alarm_rise_b;
    logic [1:0] evt_count_b;
    logic       flag_err_b;
    logic [1:0] last_rel_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       alarm;
        logic       rise;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
        logic       err;
        logic [1:0] rel;
    } exp_t;

    exp_t sbq[$];

    // Reference model state
    logic m_alarm;
    int   m_gt_run;
    int   m_ngt_run;
    int   m_cnt8;
    int   m_cnt2;
    logic m_err;
    logic [1:0] m_rel;

    localparam int P = 4;
    localparam int C = 2;

    cmp_persist_monitor #(.PERSIST(P), .CLEAR(C), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .eq         (eq),
        .gt         (gt),
        .lt         (lt),
        .clr_cnt    (clr_cnt),
        .alarm      (alarm),
        .alarm_rise (alarm_rise),
        .evt_count  (evt_count),
        .flag_err   (flag_err),
        .last_rel   (last_rel)
    );

    cmp_persist_monitor #(.PERSIST(P), .CLEAR(C), .CNT_W(2)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .eq         (eq),
        .gt         (gt),
        .lt         (lt),
        .clr_cnt    (clr_cnt),
        .alarm      (alarm_b),
        .alarm_rise (alarm_rise_b),
        .evt_count  (evt_count_b),
        .flag_err   (flag_err_b),
        .last_rel   (last_rel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_alarm   = 1'b0;
        m_gt_run  = 0;
        m_ngt_run = 0;
        m_cnt8    = 0;
        m_cnt2    = 0;
        m_err     = 1'b0;
        m_rel     = 2'b00;
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic v, input logic e, input logic g, input logic l,
                        input logic c);
        exp_t x;
        logic legal;
        logic entered;
        in_valid = v;
        eq       = e;
        gt       = g;
        lt       = l;
        clr_cnt  = c;
        legal    = ({e, g, l} == 3'b100) || ({e, g, l} == 3'b010) || ({e, g, l} == 3'b001);
        entered  = 1'b0;
        if (v && legal) begin
            m_rel = e ? 2'b00 : (g ? 2'b01 : 2'b10);
            if (g) begin
                m_ngt_run = 0;
                if (!m_alarm) begin
                    m_gt_run++;
                    if (m_gt_run == P) begin
                        m_alarm  = 1'b1;
                        entered  = 1'b1;
                        m_gt_run = 0;
                    end
                end
            end else begin
                m_gt_run = 0;
                if (m_alarm) begin
                    m_ngt_run++;
                    if (m_ngt_run == C) begin
                        m_alarm   = 1'b0;
                        m_ngt_run = 0;
                    end
                end
            end
        end
        if (c) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
            m_err  = 1'b0;
        end else begin
            if (entered && m_cnt8 < 255) m_cnt8++;
            if (entered && m_cnt2 < 3) m_cnt2++;
            if (v && !legal) m_err = 1'b1;
        end
        x.alarm = m_alarm;
        x.rise  = entered;
        x.cnt8  = 8'(m_cnt8);
        x.cnt2  = 2'(m_cnt2);
        x.err   = m_err;
        x.rel   = m_rel;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        checks++;
        if (alarm !== x.alarm) begin
            errors++;
            $display("FAIL sb_alarm t=%0t got=%b exp=%b", $time, alarm, x.alarm);
        end
        checks++;
        if (alarm_rise !== x.rise) begin
            errors++;
            $display("FAIL sb_alarm_rise t=%0t got=%b exp=%b", $time, alarm_rise, x.rise);
        end
        checks++;
        if (evt_count !== x.cnt8) begin
            errors++;
            $display("FAIL sb_evt_count t=%0t got=%0d exp=%0d", $time, evt_count, x.cnt8);
        end
        checks++;
        if (evt_count_b !== x.cnt2) begin
            errors++;
            $display("FAIL sb_evt_count_w2 t=%0t got=%0d exp=%0d", $time, evt_count_b, x.cnt2);
        end
        checks++;
        if (flag_err !== x.err) begin
            errors++;
            $display("FAIL sb_flag_err t=%0t got=%b exp=%b", $time, flag_err, x.err);
        end
        checks++;
        if (last_rel !== x.rel) begin
            errors++;
            $display("FAIL sb_last_rel t=%0t got=%b exp=%b", $time, last_rel, x.rel);
        end
    endtask

    task automatic gt_s();  step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic lt_s();  step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic eq_s();  step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic gap_s(); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

    task automatic expect_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({alarm, alarm_rise, evt_count, flag_err, last_rel, evt_count_b} !== 14'd0) begin
            errors++;
            $display("FAIL %s t=%0t got alarm=%b rise=%b cnt=%0d err=%b rel=%b cnt2=%0d exp all 0",
                     tag, $time, alarm, alarm_rise, evt_count, flag_err, last_rel, evt_count_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; eq = 1'b0; gt = 1'b0; lt = 1'b0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_values");
        rst_n = 1'b1;
    endtask

    task automatic test_persist();
        for (int i = 0; i < 3; i++) begin
            gt_s();
            expect_bit("persist_not_yet", alarm, 1'b0);
        end
        gt_s();
        expect_bit("persist_alarm", alarm, 1'b1);
        expect_bit("persist_rise", alarm_rise, 1'b1);
        gap_s();
        expect_bit("persist_rise_single", alarm_rise, 1'b0);
    endtask

    task automatic test_recover();
        lt_s(); expect_bit("recover_lt1", alarm, 1'b1);
        gt_s(); expect_bit("recover_back_alarm", alarm, 1'b1);
        expect_bit("recover_no_rise", alarm_rise, 1'b0);
        lt_s(); expect_bit("recover_lt2", alarm, 1'b1);
        lt_s(); expect_bit("recover_drop", alarm, 1'b0);
    endtask

    task automatic test_broken_run();
        gt_s(); gt_s(); gt_s(); eq_s();
        gt_s(); gt_s(); gt_s();
        expect_bit("broken_run_no_alarm", alarm, 1'b0);
        eq_s();
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) begin
            gt_s();
            if (i < 3) repeat (3) gap_s();
        end
        expect_bit("gaps_alarm", alarm, 1'b1);
        lt_s(); lt_s();
    endtask

    task automatic test_illegal();
        gt_s(); gt_s();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_bit("illegal_err", flag_err, 1'b1);
        gt_s();
        expect_bit("illegal_held_no_alarm", alarm, 1'b0);
        gt_s();
        expect_bit("illegal_then_alarm", alarm, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_bit("clr_err", flag_err, 1'b0);
        lt_s(); lt_s();
    endtask

    task automatic test_saturation();
        for (int ep = 0; ep < 5; ep++) begin
            repeat (4) gt_s();
            lt_s(); lt_s();
        end
        checks++;
        if (evt_count_b !== 2'd3) begin
            errors++;
            $display("FAIL sat_w2 got=%0d exp=3", evt_count_b);
        end
        repeat (3) gt_s();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_bit("clr_beats_inc_alarm", alarm, 1'b1);
        lt_s(); lt_s();
    endtask

    task automatic async_reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        gt_s(); gt_s();
        async_reset_pulse("async_reset_arming");
        repeat (4) gt_s();
        async_reset_pulse("async_reset_alarm_rise");
        repeat (3) gt_s();
        expect_bit("post_reset_needs_4", alarm, 1'b0);
        gt_s();
        expect_bit("post_reset_alarm", alarm, 1'b1);
    endtask

    initial begin
        test_reset();
        test_persist();
        test_recover();
        test_broken_run();
        test_gaps();
        test_illegal();
        test_saturation();
        test_async_reset();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_persist_monitor.md
Name: cmp_persist_monitor

Overview:
- Downstream consumer of the 8-bit relational comparator's EQ/GT/LT flags.
- Qualifies the GT result over time. It raises a registered alarm only after PERSIST consecutive valid GT samples. It drops the alarm only after CLEAR consecutive valid non-GT samples.
- Counts alarm episodes and flags illegal (non-one-hot) flag patterns.
- Sits between the comparator and status/interrupt logic.

Parameters:
- PERSIST, 4: consecutive valid GT samples required to raise alarm; legal range >= 1.
- CLEAR, 2: consecutive valid non-GT (EQ or LT) samples required to drop alarm; legal range >= 1.
- CNT_W, 8: width of the saturating episode counter.

Ports:
- clk  in  1  Single clock; rising edge.
- rst_n  in  1  Reset; asynchronous assert, active-low.
- in_valid  in  1  Qualifies eq/gt/lt this cycle.
- eq  in  1  Comparator equality flag.
- gt  in  1  Comparator greater-than flag.
- lt  in  1  Comparator less-than flag.
- clr_cnt  in  1  Synchronous clear of evt_count and flag_err.
- alarm  out  1  Qualified GT condition; registered.
- alarm_rise  out  1  One-cycle pulse on each 0->1 transition of alarm.
- evt_count  out  CNT_W  Number of alarm episodes; saturating.
- flag_err  out  1  Sticky: a valid sample was not one-hot.
- last_rel  out  2  Last legal valid sample: 00 EQ, 01 GT, 10 LT.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, run counter = 0.
  - alarm = 0, alarm_rise = 0, evt_count = 0, flag_err = 0, last_rel = 00.
- Sampling:
  - State advances only on cycles with in_valid = 1.
  - in_valid = 0 cycles hold state and run counter. Gaps do not break persistence.
- Legality:
  - A valid sample is legal only if {eq,gt,lt} is exactly one-hot.
  - Illegal valid sample: set flag_err (sticky). State, run, last_rel and alarm are unchanged.
- Run counter: width $clog2(max(PERSIST,CLEAR)+1).
- State machine (legal valid samples only):
  - IDLE:
    - gt: if PERSIST == 1, go to ALARM; else run = 1 and go to ARMING.
    - eq or lt: stay; run = 0.
  - ARMING:
    - gt: run++. When run+1 == PERSIST, go to ALARM with run = 0.
    - eq or lt: go to IDLE; run = 0.
  - ALARM:
    - gt: stay.
    - eq or lt: if CLEAR == 1, go to IDLE; else run = 1 and go to RECOVER.
  - RECOVER:
    - gt: go to ALARM; run = 0.
    - eq or lt: run++. When run+1 == CLEAR, go to IDLE with run = 0.
- Outputs:
  - alarm = 1 in ALARM and RECOVER; registered from next-state.
  - Latency: alarm rises in the cycle after the clock edge that samples the PERSIST-th consecutive GT. It falls likewise after the CLEAR-th non-GT sample.
  - alarm_rise = 1 for exactly one cycle, coincident with the first cycle alarm = 1.
  - A RECOVER->ALARM transition does not pulse alarm_rise and does not count.
- evt_count:
  - Increments by 1 on each entry into ALARM from IDLE or ARMING.
  - Saturates at 2^CNT_W - 1; no wrap.
- clr_cnt:
  - Zeroes evt_count and flag_err next edge.
  - Wins over a coincident increment or error: result is 0.
  - Does not affect state or alarm.
- last_rel: updated on every legal valid sample.
- Reset mid-operation: immediate return to reset values; no pulse generated.

Decomposition:
- Package cmp_pkg:
  - rel_e enum (REL_EQ = 2'b00, REL_GT = 2'b01, REL_LT = 2'b10).
  - mon_state_e enum (IDLE, ARMING, ALARM, RECOVER).
  - Shared by the comparator stage and this monitor.
- One sub-module: sat_counter (parameter W; inputs inc, clr, where clr has priority; saturating output). Used for evt_count.

Test Plan:
- PERSIST=4, CLEAR=2:
  - Apply 4 valid GT samples -> alarm = 1 and alarm_rise pulses once, in the cycle after the 4th sample edge; evt_count = 1.
  - Apply GT,GT,GT,EQ,GT,GT,GT -> alarm stays 0; state returns to IDLE after the EQ.
- In ALARM:
  - Apply LT,GT,LT,LT -> alarm stays 1 through LT,GT,LT, then drops after the 2nd consecutive LT.
  - RECOVER->ALARM produces no alarm_rise; evt_count is unchanged.
- Interleave in_valid = 0 gaps of 3 cycles between 4 GT samples -> alarm asserts after the 4th valid GT.
- Valid sample {eq,gt,lt} = 3'b110 while in ARMING with run = 2 -> flag_err = 1; run and state are held.
  - Next 2 GT samples raise alarm.
  - clr_cnt then clears flag_err and evt_count to 0.
- CNT_W = 2:
  - Generate 5 episodes -> evt_count = 3 (saturated).
  - Assert clr_cnt in the same cycle as a 6th episode entry -> evt_count = 0.
- Drop rst_n asynchronously mid-ARMING and mid-ALARM -> all outputs return to reset values immediately.
  - After release, 4 GT samples are again required to raise alarm.
